lb_line_writer: RTL

Write-side controller for the VGA ping-pong line buffer. Each time the display moves to a new pair of scan lines (edge on VgaLineCount[1]), it requests the next source line, accepts pixels over a valid/ready stream and produces the LB_WR_ADDR / LB_WR_DATA / LB_WR_N write strobes. The line-buffer read side routes those strobes to whichever SRAM bank is not being displayed. The block sits between the pixel source (frame store or capture path) and the line-buffer read side.

---
 rtl/lb_line_writer_if.sv | 22 ++
 rtl/lb_line_writer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/lb_line_writer_if.sv
// Source-stream and line-buffer write bus for lb_line_writer.
// master = the line writer, slave = its environment (pixel source / line-buffer read side).
interface lb_line_writer_if;
    logic [15:0] SRC_DATA;
    logic        SRC_VALID;
    logic        SRC_READY;
    logic        LINE_REQ;
    logic [7:0]  LINE_NUM;
    logic [9:0]  LB_WR_ADDR;
    logic [15:0] LB_WR_DATA;
    logic        LB_WR_N;

    modport master (
        input  SRC_DATA, SRC_VALID,
        output SRC_READY, LINE_REQ, LINE_NUM, LB_WR_ADDR, LB_WR_DATA, LB_WR_N
    );

    modport slave (
        output SRC_DATA, SRC_VALID,
        input  SRC_READY, LINE_REQ, LINE_NUM, LB_WR_ADDR, LB_WR_DATA, LB_WR_N
    );
endinterface

// File: rtl/lb_line_writer.sv
// Write side of the VGA ping-pong line buffer: on every edge of VgaLineCount[1] it
// requests the next source line and streams LINE_PIXELS pixels into the idle bank.
module lb_line_writer #(
    parameter int LINE_PIXELS = 640,
    parameter int WR_BASE     = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [8:0]           VgaLineCount,
    lb_line_writer_if.master     bus,
    output logic                 BUSY,
    output logic                 OVERRUN,
    input  logic                 OVR_CLR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    localparam logic [9:0] LAST_IDX  = 10'(LINE_PIXELS - 1);
    localparam logic [9:0] BASE_ADDR = 10'(WR_BASE);

    state_t      state_q, state_d;
    logic        lc1_q, lc1_d;
    logic        line_req_q, line_req_d;
    logic [7:0]  line_num_q, line_num_d;
    logic [9:0]  pix_cnt_q, pix_cnt_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        wr_n_q, wr_n_d;
    logic        overrun_q, overrun_d;

    logic        tog;
    logic        accept;
    logic        last_accept;
    logic        start_req;

    // Only line pairs matter, so bit 0 of the line count is deliberately ignored.
    logic        unused_lsb;
    assign unused_lsb = VgaLineCount[0];

    always_comb begin
        tog         = VgaLineCount[1] ^ lc1_q;
        accept      = (state_q == FILL) && bus.SRC_VALID;
        last_accept = accept && (pix_cnt_q == LAST_IDX);
        start_req   = 1'b0;

        state_d    = state_q;
        lc1_d      = VgaLineCount[1];
        line_req_d = 1'b0;
        line_num_d = line_num_q;
        pix_cnt_d  = pix_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_n_d     = 1'b1;
        overrun_d  = OVR_CLR ? 1'b0 : overrun_q;

        // An accepted pixel is always written, even when a new line pre-empts this one.
        if (accept) begin
            wr_addr_d = BASE_ADDR + pix_cnt_q;
            wr_data_d = bus.SRC_DATA;
            wr_n_d    = 1'b0;
            pix_cnt_d = pix_cnt_q + 10'd1;
        end

        case (state_q)
            IDLE: begin
                if (tog) start_req = 1'b1;
            end
            REQ: begin
                if (tog) begin
                    start_req = 1'b1;
                    overrun_d = 1'b1;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // A toggle landing on the final accept is a clean hand-over, not an overrun.
                if (tog) begin
                    start_req = 1'b1;
                    if (!last_accept) overrun_d = 1'b1;
                end else if (last_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_req) begin
            state_d    = REQ;
            line_req_d = 1'b1;
            line_num_d = VgaLineCount[8:1] + 8'd1;
            pix_cnt_d  = 10'd0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            lc1_q      <= 1'b0;
            line_req_q <= 1'b0;
            line_num_q <= 8'd0;
            pix_cnt_q  <= 10'd0;
            wr_addr_q  <= 10'd0;
            wr_data_q  <= 16'd0;
            wr_n_q     <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lc1_q      <= lc1_d;
            line_req_q <= line_req_d;
            line_num_q <= line_num_d;
            pix_cnt_q  <= pix_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_n_q     <= wr_n_d;
            overrun_q  <= overrun_d;
        end
    end

    // Ready and busy come straight from state so an asynchronous reset drops them at once.
    assign bus.SRC_READY  = (state_q == FILL);
    assign BUSY           = (state_q != IDLE);
    assign bus.LINE_REQ   = line_req_q;
    assign bus.LINE_NUM   = line_num_q;
    assign bus.LB_WR_ADDR = wr_addr_q;
    assign bus.LB_WR_DATA = wr_data_q;
    assign bus.LB_WR_N    = wr_n_q;
    assign OVERRUN        = overrun_q;

endmodule
